// File: rtl/three_way_light_ctrl.sv
// Three-switch (staircase) light sequencer.
// Each raw switch passes through a 2-FF synchroniser and a per-switch debouncer.
// An odd number of debounced edges in one cycle is a net toggle. The toggle
// drives a light FSM (OFF/ON/WARN) that has an auto-off timeout and a
// warning window before the light turns off.
// Ports:
//   clk       - system clock, rising edge
//   rst_n     - asynchronous active-low reset
//   x1,x2,x3  - raw switch inputs, asynchronous to clk
//   force_off - synchronous master-off level; overrides toggles
//   light     - registered lamp drive
//   warn      - registered, high during the last WARN_CYCLES of on-time
//   sw_db     - registered debounced switch levels {x3,x2,x1}
//   toggle    - registered one-cycle pulse on each accepted net toggle
module three_way_light_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 64,
  parameter int unsigned WARN_CYCLES     = 16,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       x1,
  input  logic       x2,
  input  logic       x3,
  input  logic       force_off,
  output logic       light,
  output logic       warn,
  output logic [2:0] sw_db,
  output logic       toggle
);

  typedef enum logic [1:0] {ST_OFF, ST_ON, ST_WARN} state_t;

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] WARN_AT  = CNT_W'(WARN_CYCLES);

  logic [2:0]            sync1, sync2;
  logic [2:0][CNT_W-1:0] db_cnt;
  logic [2:0]            sw_prev;
  logic                  toggle_next;
  state_t                state, state_next;
  logic [CNT_W-1:0]      timer, timer_next;

  // Two-stage synchroniser for the asynchronous switch pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {x3, x2, x1};
      sync2 <= sync1;
    end
  end

  // Debounce: a change is accepted only after DEBOUNCE_CYCLES consecutive
  // cycles of the synced level differing from the accepted level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt <= '0;
      sw_db  <= '0;
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (sync2[i] == sw_db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          sw_db[i]  <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Net toggle: parity of the per-switch edges, so paired edges cancel.
  assign toggle_next = ^(sw_db ^ sw_prev);

  always_comb begin
    state_next = state;
    timer_next = timer;
    case (state)
      ST_OFF: begin
        timer_next = '0;
        if (!force_off && toggle_next) begin
          state_next = ST_ON;
          timer_next = TMO_LOAD;
        end
      end
      ST_ON: begin
        if (timer != '0) timer_next = timer - 1'b1;
        if (force_off || toggle_next) begin
          state_next = ST_OFF;
          timer_next = '0;
        end else if (timer == WARN_AT) begin
          state_next = ST_WARN;
        end
      end
      ST_WARN: begin
        if (timer != '0) timer_next = timer - 1'b1;
        if (force_off) begin
          state_next = ST_OFF;
          timer_next = '0;
        end else if (toggle_next) begin
          // A toggle during the warning window extends rather than turns off.
          state_next = ST_ON;
          timer_next = TMO_LOAD;
        end else if (timer == '0) begin
          state_next = ST_OFF;
        end
      end
      default: begin
        state_next = ST_OFF;
        timer_next = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so the light follows the
  // toggle in the same cycle the toggle pulse is visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_prev <= '0;
      toggle  <= 1'b0;
      state   <= ST_OFF;
      timer   <= '0;
      light   <= 1'b0;
      warn    <= 1'b0;
    end else begin
      sw_prev <= sw_db;
      toggle  <= toggle_next;
      state   <= state_next;
      timer   <= timer_next;
      light   <= (state_next != ST_OFF);
      warn    <= (state_next == ST_WARN);
    end
  end

endmodule

// File: tb/tb_three_way_light_ctrl.sv
module tb_three_way_light_ctrl;

  localparam int D = 4;
  localparam int T = 64;
  localparam int W = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       x1 = 1'b0, x2 = 1'b0, x3 = 1'b0;
  logic       force_off = 1'b0;
  logic       light, warn, toggle;
  logic [2:0] sw_db;

  three_way_light_ctrl #(
    .DEBOUNCE_CYCLES(D),
    .TIMEOUT_CYCLES (T),
    .WARN_CYCLES    (W),
    .CNT_W          (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .x1       (x1),
    .x2       (x2),
    .x3       (x3),
    .force_off(force_off),
    .light    (light),
    .warn     (warn),
    .sw_db    (sw_db),
    .toggle   (toggle)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int compares = 0;

  // Reference model: synced level is the raw sample from two edges ago;
  // debounce counts consecutive disagreeing cycles; the light is modelled as
  // the number of on-cycles remaining (0 = off, 1..W = warning window).
  logic [2:0] m_d1, m_d2, m_db, m_db_prev;
  int         m_run [3];
  int         m_rem;
  logic       m_tog;

  task automatic model_reset();
    m_d1 = '0; m_d2 = '0; m_db = '0; m_db_prev = '0;
    for (int i = 0; i < 3; i++) m_run[i] = 0;
    m_rem = 0;
    m_tog = 1'b0;
  endtask

  task automatic model_edge(input logic [2:0] r, input logic f);
    logic t;
    t = ^(m_db ^ m_db_prev);
    m_db_prev = m_db;
    m_tog = t;
    if (f) m_rem = 0;
    else if (t) m_rem = (m_rem <= W) ? T : 0;
    else if (m_rem > 0) m_rem = m_rem - 1;
    for (int i = 0; i < 3; i++) begin
      if (m_d2[i] != m_db[i]) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] == D) begin
          m_db[i] = m_d2[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_d2 = m_d1;
    m_d1 = r;
  endtask

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    compares++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("light", {2'b0, light}, {2'b0, m_rem > 0});
    chk("warn", {2'b0, warn}, {2'b0, (m_rem > 0) && (m_rem <= W)});
    chk("sw_db", sw_db, m_db);
    chk("toggle", {2'b0, toggle}, {2'b0, m_tog});
  endtask

  logic [2:0] cur = '0;
  logic       seen_tog;

  task automatic step(input logic [2:0] r, input logic f);
    @(negedge clk);
    {x3, x2, x1} = r;
    force_off = f;
    @(posedge clk);
    if (rst_n) model_edge(r, f);
    else model_reset();
    #1;
    vectors++;
    check_model();
    if (toggle) seen_tog = 1'b1;
  endtask

  initial begin
    model_reset();
    // Reset with all switches low.
    for (int k = 0; k < 3; k++) step(3'b000, 1'b0);
    chk("rst_light", {2'b0, light}, 3'b000);
    chk("rst_sw_db", sw_db, 3'b000);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) step(3'b000, 1'b0);

    // x1 rises: sw_db at edge 6, toggle and light at edge 7.
    cur = 3'b001;
    for (int k = 1; k <= 8; k++) begin
      step(cur, 1'b0);
      if (k == 5) chk("db_e5", sw_db, 3'b000);
      if (k == 6) chk("db_e6", sw_db, 3'b001);
      if (k == 7) chk("on_e7", {light, warn, toggle}, 3'b101);
      if (k == 8) chk("tog_e8", {2'b0, toggle}, 3'b000);
    end

    // Short glitch on x1 is ignored.
    seen_tog = 1'b0;
    step(3'b000, 1'b0);
    step(3'b000, 1'b0);
    for (int k = 0; k < 10; k++) step(cur, 1'b0);
    chk("glitch", {light, sw_db[0], seen_tog}, 3'b110);

    // x2 rises: toggle turns the light off.
    cur = 3'b011;
    for (int k = 0; k < 8; k++) step(cur, 1'b0);
    chk("x2_off", {2'b0, light}, 3'b000);

    // Full timeout profile after x3 turns the light on.
    cur = 3'b111;
    for (int k = 1; k <= 71; k++) begin
      step(cur, 1'b0);
      if (k == 7)  chk("to_on", {2'b0, light}, 3'b001);
      if (k == 54) chk("to_prewarn", {light, warn, 1'b0}, 3'b100);
      if (k == 55) chk("to_warn", {light, warn, 1'b0}, 3'b110);
      if (k == 70) chk("to_last", {light, warn, 1'b0}, 3'b110);
      if (k == 71) chk("to_off", {light, warn, 1'b0}, 3'b000);
    end

    // Turn on, wait for warning, then extend with a toggle.
    cur = 3'b110;
    for (int k = 0; k < 100 && !warn; k++) step(cur, 1'b0);
    chk("warn_reached", {2'b0, warn}, 3'b001);
    cur = 3'b100;
    for (int k = 0; k < 7; k++) step(cur, 1'b0);
    chk("extend", {light, warn, toggle}, 3'b101);

    // Two simultaneous edges cancel; three give one toggle.
    seen_tog = 1'b0;
    cur = 3'b111;
    for (int k = 0; k < 8; k++) step(cur, 1'b0);
    chk("pair_cancel", {light, seen_tog, 1'b0}, 3'b100);
    seen_tog = 1'b0;
    cur = 3'b000;
    for (int k = 0; k < 8; k++) step(cur, 1'b0);
    chk("triple", {light, seen_tog, 1'b0}, 3'b010);

    // force_off behaviour.
    cur = 3'b100;
    for (int k = 0; k < 8; k++) step(cur, 1'b0);
    chk("fo_pre_on", {2'b0, light}, 3'b001);
    step(cur, 1'b1);
    chk("fo_off", {2'b0, light}, 3'b000);
    seen_tog = 1'b0;
    cur = 3'b000;
    for (int k = 0; k < 8; k++) step(cur, 1'b1);
    chk("fo_hold", {light, seen_tog, 1'b0}, 3'b010);
    cur = 3'b001;
    for (int k = 0; k < 8; k++) step(cur, 1'b0);
    chk("fo_release", {2'b0, light}, 3'b001);

    // Asynchronous reset in the warning window with x1 held high.
    for (int k = 0; k < 80 && !warn; k++) step(cur, 1'b0);
    chk("warn_pre_rst", {warn, sw_db[0], 1'b0}, 3'b110);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst", {light, warn, 1'b0}, 3'b000);
    chk("async_rst_db", sw_db, 3'b000);
    model_reset();
    for (int k = 0; k < 2; k++) step(cur, 1'b0);
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step(cur, 1'b0);
      if (k == 6) chk("post_rst_db", sw_db, 3'b001);
      if (k == 7) chk("post_rst_on", {light, toggle, 1'b0}, 3'b110);
    end

    // Randomised phase: alternating bouncy and calm segments.
    for (int seg = 0; seg < 16; seg++) begin
      int unsigned flip_den;
      flip_den = (seg % 2 == 0) ? 3 : 60;
      for (int k = 0; k < 200; k++) begin
        logic fo;
        for (int b = 0; b < 3; b++)
          if ($urandom_range(flip_den - 1, 0) == 0) cur[b] = ~cur[b];
        fo = ($urandom_range(39, 0) == 0);
        step(cur, fo);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
